cp0_exc_unit: RTL
=================

// Module: cp0_exc_unit
// PURPOSE
//  Coprocessor-0 for the P7 MIPS pipeline. It produces the NPC redirect inputs intreq and epc,
//  and it consumes the NPC eret event.
//  - Arbitrates hardware interrupts against synchronous exceptions reported by the M stage.
//  - On exception/interrupt entry, captures EPC/Cause and sets SR.EXL.
//  - Serves mfc0 reads and mtc0 writes.
// PARAMETERS
//  PRID     32'h2017_1204  constant value returned by PRId (reg 15)
//  HWINT_W  6              hardware interrupt lines; fixed to 6 (IP/IM[15:10])
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous active-low reset
//  hw_int      in   6   level interrupt requests (timer0, timer1, ext ...)
//  exc_valid   in   1   M-stage instruction raised a synchronous exception this cycle
//  exc_code    in   5   ExcCode of that exception (4 AdEL, 5 AdES, 10 RI, 12 Ov)
//  victim_pc   in   32  PC of the M-stage instruction (or of the next valid one when bubble)
//  victim_bd   in   1   M-stage instruction sits in a branch delay slot
//  eret        in   1   M-stage eret retiring this cycle
//  cp0_we      in   1   mtc0 write enable (M stage)
//  cp0_addr    in   5   rd field for mtc0/mfc0
//  cp0_wdata   in   32  mtc0 data
//  cp0_rdata   out  32  mfc0 read data, combinational on cp0_addr
//  intreq      out  1   take exception/interrupt now; NPC jumps to 0x0000_4180, pipeline flushes
//  epc         out  32  current EPC register; NPC target on eret
// BEHAVIOUR
//  Registers
//   - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
//   - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
//   - EPC(14): 32 bits, bits[1:0] always 0.
//   - PRId(15): PRID.
//   - Any other cp0_addr reads 0.
//  Reset (async, reset_n low)
//   - SR=0, Cause=0, EPC=0.
//   - intreq=0 and epc=0 throughout, regardless of inputs.
//  State machine on SR.EXL
//   - USER (EXL=0) -> HANDLER on the edge where intreq=1.
//   - HANDLER (EXL=1) -> USER on the edge where eret=1.
//   - No entry from HANDLER: exceptions and interrupts are masked while EXL=1.
//  Arbitration (combinational, same cycle)
//   - int_pend = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL
//   - exc_take = exc_valid & ~SR.EXL
//   - intreq = int_pend | exc_take; interrupt wins over exception.
//  Entry (edge with intreq=1)
//   - EPC <= (victim_bd ? victim_pc-4 : victim_pc) & ~3
//   - Cause.BD <= victim_bd
//   - Cause.ExcCode <= int_pend ? 0 : exc_code
//   - SR.EXL <= 1
//   - Same-cycle mtc0 is discarded completely; the flushed instruction must not commit.
//  Cause.IP
//   - Registered copy of hw_int every cycle, unconditionally, including in HANDLER; 1-cycle latency.
//   - An interrupt asserted at edge N can raise intreq from cycle N+1.
//  mtc0 (cp0_we & ~intreq)
//   - SR: writes IM, EXL, IE only.
//   - EPC: writes wdata & ~3.
//   - Cause and PRId writes are ignored.
//   - Takes effect at the edge; cp0_rdata shows the old value in the write cycle (no internal bypass).
//  eret
//   - epc output is the pre-edge EPC value, so NPC jumps to the old EPC.
//   - At the edge: EXL <= 0. If mtc0 to SR in the same cycle, eret's EXL clear wins; IM/IE still written.
//   - eret with EXL=0 is legal: jumps to EPC, EXL stays 0.
//  Reset mid-handler: returns to USER immediately; pending hw_int is re-evaluated only after IE is set again.
//  Arithmetic: victim_pc-4 wraps modulo 2^32 (victim_pc=0 gives EPC=0xFFFF_FFFC).
// TESTING
//  1. Reset release, all inputs 0 -> SR=Cause=EPC=0, intreq=0, rdata(15)=PRID.
//  2. mtc0 SR=0x0000_0401, hw_int[0]=1 -> intreq=1 the cycle after IP samples.
//     Edge: EPC=victim_pc, ExcCode=0, EXL=1; intreq drops next cycle.
//  3. exc_valid, code 12, victim_pc=0x3010, bd=1 -> EPC=0x300C, Cause=0x8000_0030, EXL=1.
//  4. exc_valid and an enabled hw_int in the same cycle -> ExcCode=0, single entry; same-cycle mtc0 EPC dropped.
//  5. In HANDLER: exc_valid=1 and hw_int active -> intreq stays 0.
//     eret -> epc=old EPC, EXL=0; int re-taken next cycle.
//  6. reset_n low while EXL=1 with hw_int active -> immediate SR=0, intreq=0, no re-entry after release.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
//   Coprocessor-0 for the P7 MIPS pipeline.
//   - Arbitrates level hardware interrupts against synchronous exceptions
//     reported by the M stage. When the unit decides to take one, it raises
//     intreq, which redirects the NPC to the handler.
//   - On entry it captures EPC and Cause and sets SR.EXL. While EXL is set,
//     further entries are masked.
//   - It serves mfc0 reads (combinational on cp0_addr) and mtc0 writes.
//   - The NPC uses epc as the eret target.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   hw_int     level interrupt requests, sampled into Cause.IP every cycle
//   exc_valid  M-stage synchronous exception this cycle
//   exc_code   ExcCode of that exception
//   victim_pc  PC of the M-stage instruction
//   victim_bd  M-stage instruction sits in a branch delay slot
//   eret       M-stage eret retiring this cycle
//   cp0_we     mtc0 write enable
//   cp0_addr   CP0 register number for mtc0/mfc0
//   cp0_wdata  mtc0 write data
//   cp0_rdata  mfc0 read data (combinational)
//   intreq     take exception/interrupt now
//   epc        current EPC register
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
    parameter logic [31:0] PRID    = 32'h2017_1204,
    parameter int          HWINT_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [HWINT_W-1:0] hw_int,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        victim_pc,
    input  logic               victim_bd,
    input  logic               eret,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               intreq,
    output logic [31:0]        epc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR.EXL is the state of the exception FSM.
    typedef enum logic {
        USER    = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [HWINT_W-1:0]  im_q, im_d;
    logic                ie_q, ie_d;
    logic [HWINT_W-1:0]  ip_q, ip_d;
    logic                bd_q, bd_d;
    logic [4:0]          exc_code_q, exc_code_d;
    logic [31:0]         epc_q, epc_d;

    logic                exl;
    logic                int_pend;
    logic                exc_take;
    logic                take;
    logic                mtc0_wr;
    logic [31:0]         entry_pc;

    assign exl      = (state_q == HANDLER);
    assign int_pend = (|(ip_q & im_q)) & ie_q & ~exl;
    assign exc_take = exc_valid & ~exl;
    assign take     = int_pend | exc_take;

    // Registers are already cleared while reset is held, but exc_valid is not
    // gated by EXL alone, so intreq is forced low explicitly during reset.
    assign intreq   = take & reset_n;
    assign epc      = epc_q;

    // An instruction flushed by the entry must not commit its mtc0.
    assign mtc0_wr  = cp0_we & ~take;

    // A delay-slot victim restarts at its branch; wraps modulo 2^32.
    assign entry_pc = victim_bd ? (victim_pc - 32'd4) : victim_pc;

    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        ip_d       = hw_int;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (take) begin
            epc_d      = entry_pc & ~32'd3;
            bd_d       = victim_bd;
            exc_code_d = int_pend ? 5'd0 : exc_code;
            state_d    = HANDLER;
        end else begin
            if (mtc0_wr && (cp0_addr == ADDR_SR)) begin
                im_d    = cp0_wdata[10 +: HWINT_W];
                ie_d    = cp0_wdata[0];
                state_d = cp0_wdata[1] ? HANDLER : USER;
            end
            if (mtc0_wr && (cp0_addr == ADDR_EPC)) begin
                epc_d = cp0_wdata & ~32'd3;
            end
            // eret's EXL clear overrides a same-cycle mtc0 to SR.
            if (eret) begin
                state_d = USER;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= USER;
            im_q       <= '0;
            ie_q       <= 1'b0;
            ip_q       <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // mfc0 read mux; unimplemented bits and registers read as zero.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_SR: begin
                cp0_rdata[10 +: HWINT_W] = im_q;
                cp0_rdata[1]             = exl;
                cp0_rdata[0]             = ie_q;
            end
            ADDR_CAUSE: begin
                cp0_rdata[31]            = bd_q;
                cp0_rdata[10 +: HWINT_W] = ip_q;
                cp0_rdata[6:2]           = exc_code_q;
            end
            ADDR_EPC:  cp0_rdata = epc_q;
            ADDR_PRID: cp0_rdata = PRID;
            default:   cp0_rdata = 32'd0;
        endcase
    end

endmodule
